// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: gates on init completion, then grants refresh,
// write and read clients in fixed priority and muxes their command buses.
module sdram_arbit #(
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_bank_addr,
    input  logic [12:0] init_addr,
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_bank_addr,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_bank_addr,
    input  logic [12:0] wr_sdram_addr,
    input  logic [15:0] wr_sdram_data,
    input  logic        wr_sdram_en,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_bank_addr,
    input  logic [12:0] rd_sdram_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_bank_addr,
    output logic [12:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    output logic [2:0]  state_dbg
);

    // Handshake: a client holds *_req until its *_en rises, then owns the bus
    // until it pulses *_end; *_end from any other client is ignored.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   aref_en_q, aref_en_d;
    logic   wr_en_q, wr_en_d;
    logic   rd_en_q, rd_en_d;

    always_comb begin
        state_d   = state_q;
        aref_en_d = aref_en_q;
        wr_en_d   = wr_en_q;
        rd_en_d   = rd_en_q;
        case (state_q)
            IDLE: begin
                if (init_end) state_d = ARBIT;
            end
            ARBIT: begin
                if (aref_req) begin
                    state_d   = AREF;
                    aref_en_d = 1'b1;
                end else if (wr_req) begin
                    state_d = WRITE;
                    wr_en_d = 1'b1;
                end else if (rd_req) begin
                    state_d = READ;
                    rd_en_d = 1'b1;
                end
            end
            AREF: begin
                if (aref_end) begin
                    state_d   = ARBIT;
                    aref_en_d = 1'b0;
                end
            end
            WRITE: begin
                if (wr_end) begin
                    state_d = ARBIT;
                    wr_en_d = 1'b0;
                end
            end
            READ: begin
                if (rd_end) begin
                    state_d = ARBIT;
                    rd_en_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                aref_en_d = 1'b0;
                wr_en_d   = 1'b0;
                rd_en_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            aref_en_q <= aref_en_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
        end
    end

    // Bus mux decodes the state register only, so an async reset reroutes it at once.
    always_comb begin
        sdram_cmd       = CMD_NOP;
        sdram_bank_addr = 2'b11;
        sdram_addr      = 13'h1FFF;
        sdram_dq_out    = 16'h0000;
        sdram_dq_oe     = 1'b0;
        case (state_q)
            IDLE: begin
                sdram_cmd       = init_cmd;
                sdram_bank_addr = init_bank_addr;
                sdram_addr      = init_addr;
            end
            AREF: begin
                sdram_cmd       = aref_cmd;
                sdram_bank_addr = aref_bank_addr;
                sdram_addr      = aref_addr;
            end
            WRITE: begin
                sdram_cmd       = wr_cmd;
                sdram_bank_addr = wr_bank_addr;
                sdram_addr      = wr_sdram_addr;
                sdram_dq_out    = wr_sdram_data;
                sdram_dq_oe     = wr_sdram_en;
            end
            READ: begin
                sdram_cmd       = rd_cmd;
                sdram_bank_addr = rd_bank_addr;
                sdram_addr      = rd_sdram_addr;
            end
            default: ;
        endcase
    end

    assign aref_en   = aref_en_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign state_dbg = state_q;

endmodule
